// File: rtl/rand_server_pkg.sv
// Shared types and constants for the bounded random-number server.
// Holds the FSM encoding, datapath widths, LFSR tap positions and the mask helper.
package rand_server_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LFSR_W = 16;
    localparam int OUT_W  = 8;

    localparam int TAP_A = 15;
    localparam int TAP_B = 12;
    localparam int TAP_C = 3;
    localparam int TAP_D = 0;

    // Smallest all-ones value covering lim_eff-1, so masked candidates waste at most half the range.
    function automatic logic [OUT_W-1:0] mask_for(input logic [OUT_W-1:0] lim_eff);
        logic [OUT_W-1:0] need;
        logic [OUT_W-1:0] m;
        need = lim_eff - 1'b1;
        m    = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (m < need) m = {m[OUT_W-2:0], 1'b1};
        end
        return m;
    endfunction

endpackage

// File: rtl/rand_lfsr16.sv
// 16-bit Fibonacci LFSR, advances one step per cycle while step is high; no backpressure.
// A zero seed is replaced by 1 so the register can never lock up.
module rand_lfsr16
    import rand_server_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hAAAA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] lfsr
);

    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              fb;

    always_comb begin
        fb     = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];
        lfsr_d = step ? {lfsr_q[LFSR_W-2:0], fb} : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= INIT;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/rand_server.sv
// Round-robin server of bounded random draws; ack 2..MAX_TRY+1 cycles after grant, req held until ack.
// RAND_SERVER_FREERUN_EN: LFSR steps every cycle instead of only while drawing.
module rand_server
    import rand_server_pkg::*;
#(
    parameter int                N_REQ   = 4,
    parameter logic [LFSR_W-1:0] SEED    = 16'hAAAA,
    parameter int                MAX_TRY = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [OUT_W*N_REQ-1:0] lim,
    output logic [N_REQ-1:0]       ack,
    output logic [OUT_W-1:0]       rnd_data,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TRY_W = 4;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, grant_q, grant_d, grant_c;
    logic [OUT_W-1:0]  lim_q, lim_d, mask_q, mask_d, rnd_q, rnd_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [OUT_W-1:0]  lim_sel, lim_eff_c, cand;
    logic              found, accept, fallback, lfsr_step;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_hi_unused;

`ifdef RAND_SERVER_FREERUN_EN
    assign lfsr_step = 1'b1;
`else
    assign lfsr_step = (state_q == DRAW);
`endif

    rand_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .lfsr  (lfsr)
    );

    assign lfsr_hi_unused = ^lfsr[LFSR_W-1:OUT_W];

    // First requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        grant_c = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found   = 1'b1;
                grant_c = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        lim_sel   = lim[{grant_c, 3'b000} +: OUT_W];
        lim_eff_c = (lim_sel == '0) ? OUT_W'(1) : lim_sel;
        cand      = lfsr[OUT_W-1:0] & mask_q;
        accept    = (cand < lim_q);
        fallback  = !accept && (try_q == TRY_W'(MAX_TRY - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            lim_q   <= OUT_W'(1);
            mask_q  <= '0;
            try_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            try_q   <= try_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = DRAW;
            DRAW:    if (accept || fallback) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant-time values are frozen so later req/lim changes cannot disturb the draw.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        try_d   = try_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = grant_c;
                    lim_d   = lim_eff_c;
                    mask_d  = mask_for(lim_eff_c);
                    try_d   = '0;
                end
            end
            DRAW: begin
                if (accept)        rnd_d = cand;
                else if (fallback) rnd_d = {1'b0, cand[OUT_W-1:1]};
                else               try_d = try_q + 1'b1;
            end
            DONE: begin
                ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ack  = '0;
        busy = (state_q != IDLE);
        if (state_q == DONE) ack[grant_q] = 1'b1;
    end

    assign rnd_data = rnd_q;

endmodule

// File: tb/tb_rand_server.sv
`timescale 1ns/1ps
module tb_rand_server;

    localparam int          N_REQ   = 4;
    localparam int          MAX_TRY = 8;
    localparam logic [15:0] SEED    = 16'hAAAA;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [31:0] lim   = '0;
    logic [3:0]  ack;
    logic [7:0]  rnd_data;
    logic        busy;

    // Second instance whose seed keeps the low two LFSR bits at 11 for eight draws.
    logic [3:0]  req2 = '0;
    logic [31:0] lim2 = '0;
    logic [3:0]  ack2;
    logic [7:0]  rnd2;
    logic        busy2;

    rand_server #(.N_REQ(N_REQ), .SEED(SEED), .MAX_TRY(MAX_TRY)) dut (
        .clk(clk), .reset(reset), .req(req), .lim(lim),
        .ack(ack), .rnd_data(rnd_data), .busy(busy)
    );

    rand_server #(.N_REQ(N_REQ), .SEED(16'hE38F), .MAX_TRY(MAX_TRY)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .lim(lim2),
        .ack(ack2), .rnd_data(rnd2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[12] ^ s[3] ^ s[0]};
    endfunction

    // Transaction-level model: a whole draw is resolved at its grant edge,
    // then the expected ack/busy/rnd_data are scheduled by cycle number.
    logic [15:0] m_lfsr   = SEED;
    int          m_ptr    = 0;
    bit          m_active = 1'b0;
    int          m_done   = 0;
    int          m_free   = 0;
    logic [3:0]  m_gvec   = '0;
    logic [7:0]  m_data   = '0;
    logic [3:0]  exp_ack  = '0;
    logic [7:0]  exp_rnd  = '0;
    logic        exp_busy = 1'b0;

    always @(posedge clk) begin
        int g, le, mk, n, cand, data;
        logic [15:0] s;
        cyc++;
        if (reset) begin
            m_lfsr   = SEED;
            m_ptr    = 0;
            m_active = 1'b0;
            m_free   = 0;
            exp_ack  = '0;
            exp_busy = 1'b0;
            exp_rnd  = '0;
        end else begin
            exp_ack = '0;
            if (!m_active && cyc >= m_free && req != '0) begin
                g = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (g < 0 && req[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
                le = int'(lim[8*g +: 8]);
                if (le == 0) le = 1;
                mk = 0;
                while (mk < le - 1) mk = mk * 2 + 1;
`ifdef RAND_SERVER_FREERUN_EN
                s = lfsr_next(m_lfsr);
`else
                s = m_lfsr;
`endif
                n = 0;
                data = 0;
                for (int k = 0; k < MAX_TRY && n == 0; k++) begin
                    cand = int'(s[7:0]) & mk;
                    s = lfsr_next(s);
                    if (cand < le) begin
                        data = cand;
                        n = k + 1;
                    end else if (k == MAX_TRY - 1) begin
                        data = cand / 2;
                        n = k + 1;
                    end
                end
`ifndef RAND_SERVER_FREERUN_EN
                m_lfsr = s;
`endif
                m_active = 1'b1;
                m_done   = cyc + n;
                m_free   = cyc + n + 2;
                m_gvec   = 4'(1 << g);
                m_data   = 8'(data);
                m_ptr    = (g + 1) % N_REQ;
            end
`ifdef RAND_SERVER_FREERUN_EN
            m_lfsr = lfsr_next(m_lfsr);
`endif
            exp_busy = m_active && cyc <= m_done;
            if (m_active && cyc == m_done) begin
                exp_ack = m_gvec;
                exp_rnd = m_data;
            end
            if (m_active && cyc > m_done) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("model_ack", int'(ack), int'(exp_ack));
            chk("model_busy", int'(busy), int'(exp_busy));
            chk("model_rnd_data", int'(rnd_data), int'(exp_rnd));
        end
    end

    task automatic wait_ack(input int max_cyc, output int lat, output logic [3:0] av,
                            output logic [7:0] dv);
        bit got;
        got = 1'b0;
        lat = 0;
        av  = '0;
        dv  = '0;
        while (!got && lat < max_cyc) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                av  = ack;
                dv  = rnd_data;
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    // Called at a negedge; waits for idle, raises one request, drops it in the ack cycle.
    task automatic draw(input int idx, input logic [7:0] lv, output int lat,
                        output logic [3:0] av, output logic [7:0] dv);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        lim[8*idx +: 8] = lv;
        req = 4'(1 << idx);
        wait_ack(20, lat, av, dv);
        req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, le, acks;
        logic [3:0] av;
        logic [7:0] dv;
        logic [7:0] sweep [8];
        logic [3:0] rr_exp [5];
        sweep  = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd100, 8'd129, 8'd255, 8'd0};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (3) @(negedge clk);
        chk("reset_ack", int'(ack), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rnd", int'(rnd_data), 0);
        reset = 1'b0;
        @(negedge clk);

        draw(0, 8'd200, lat, av, dv);
        chk("first_ack_vec", int'(av), 4'b0001);
        chk("first_latency", lat, 2);
`ifndef RAND_SERVER_FREERUN_EN
        chk("first_rnd_aa", int'(dv), 8'hAA);
`endif

        draw(1, 8'd1, lat, av, dv);
        chk("lim1_ack_vec", int'(av), 4'b0010);
        chk("lim1_latency", lat, 2);
        chk("lim1_rnd", int'(dv), 0);
        draw(1, 8'd0, lat, av, dv);
        chk("lim0_latency", lat, 2);
        chk("lim0_rnd", int'(dv), 0);

        foreach (sweep[i]) begin
            draw(i % N_REQ, sweep[i], lat, av, dv);
            le = (sweep[i] == 8'd0) ? 1 : int'(sweep[i]);
            chk("sweep_ack_vec", int'(av), 1 << (i % N_REQ));
            chk("sweep_rnd_below_lim", int'(int'(dv) < le), 1);
            chk("sweep_latency_bound", int'(lat >= 2 && lat <= MAX_TRY + 1), 1);
        end

        // lim and req change right after the grant edge; the draw must still use lim=200.
        @(negedge clk);
        lim[7:0] = 8'd200;
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        lim[7:0] = 8'd5;
        req = '0;
        wait_ack(20, lat, av, dv);
        chk("dropped_req_still_acked", int'(av), 4'b0001);

        do_reset();
        lim = {8'd16, 8'd16, 8'd16, 8'd16};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(20, lat, av, dv);
            chk("rr_order", int'(av), int'(rr_exp[n]));
            chk("rr_rnd_below_16", int'(dv < 8'd16), 1);
            if (n == 4) req = '0;
            @(posedge clk);
        end
        @(negedge clk);

        do_reset();
        lim[7:0] = 8'd200;
        req = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack != '0) acks++;
        end
        chk("abort_no_ack", acks, 0);
        draw(0, 8'd200, lat, av, dv);
        chk("after_abort_latency", lat, 2);
`ifndef RAND_SERVER_FREERUN_EN
        chk("after_abort_rnd_aa", int'(dv), 8'hAA);

        do_reset();
        lim2[7:0] = 8'd3;
        req2 = 4'b0001;
        lat = 0;
        av = '0;
        while (av == '0 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack2 != '0) begin
                av = ack2;
                dv = rnd2;
            end
        end
        req2 = '0;
        chk("fallback_ack_vec", int'(av), 4'b0001);
        chk("fallback_latency", lat, MAX_TRY + 1);
        chk("fallback_rnd", int'(dv), 1);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rand_server.md
RAND_SERVER -- requirements
Module: rand_server

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_REQ, 4: number of requesters, 2..8.
- SEED, 16'hAAAA: LFSR reset value.
- MAX_TRY, 8: rejection attempts before fallback, 1..15.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- req, in, N_REQ: per-requester draw request; held high until its ack.
- lim, in, 8*N_REQ: per-requester exclusive upper bound; slice i is [8i+7:8i].
- ack, out, N_REQ: one-cycle completion pulse, one-hot or zero.
- rnd_data, out, 8: result; valid only in the ack cycle, held otherwise.
- busy, out, 1: high in states DRAW and DONE.

Function
REQ-003 The block SHALL hold a 16-bit Fibonacci LFSR: next = {lfsr[14:0], lfsr[15]^lfsr[12]^lfsr[3]^lfsr[0]}.
REQ-004 The FSM SHALL have three states, IDLE, DRAW and DONE, with these transitions:
- IDLE -> DRAW when any req bit is high.
- DRAW -> DRAW on a rejected candidate.
- DRAW -> DONE on acceptance or fallback.
- DONE -> IDLE unconditionally.
REQ-005 In IDLE, a round-robin arbiter SHALL grant the first high req at or after pointer ptr (wrapping at N_REQ). The block SHALL latch the grant index and lim_eff = (lim slice == 0) ? 1 : lim slice.
REQ-006 On entering DRAW:
- mask SHALL be latched as the smallest (2^k)-1 with mask >= lim_eff-1 (lim_eff=1 -> mask=0).
- try SHALL be cleared.
REQ-007 Each DRAW cycle SHALL form candidate = lfsr[7:0] & mask from the current register value, then advance the LFSR.
REQ-008 Accept and retry rules in DRAW:
- candidate < lim_eff: latch rnd_data = candidate and go to DONE.
- otherwise: try++.
- If try reaches MAX_TRY-1 with a rejection: latch rnd_data = candidate >> 1 (always < lim_eff) and go to DONE.
REQ-009 In DONE:
- ack[grant] SHALL be 1 for exactly this cycle.
- ptr SHALL become (grant+1) mod N_REQ.
REQ-010 Latency: req first sampled high in IDLE at edge t SHALL yield ack at cycle t+2 on first-try acceptance, and at most t+1+MAX_TRY.
REQ-011 Requests arriving or dropped while busy SHALL NOT affect the current draw. A req dropped before ack is still acked; the result is discarded by the requester.
REQ-012 A requester that keeps req high in the cycle after its ack SHALL be treated as a new request, subject to round-robin order.
REQ-013 Changes to the lim input after grant SHALL NOT affect the current draw.
REQ-014 rnd_data SHALL always satisfy rnd_data < lim_eff of the granted requester.

Reset
REQ-015 On reset high at a clk edge:
- state = IDLE; ptr = 0; try = 0.
- ack = 0; rnd_data = 0; busy = 0.
- lfsr = SEED, or 16'h0001 if SEED == 0.
REQ-016 Reset during DRAW or DONE SHALL abort the draw with no ack pulse.

Configuration
REQ-017 Macro RAND_SERVER_FREERUN_EN:
- Defined: the LFSR SHALL advance every non-reset cycle in all states.
- Undefined: the LFSR SHALL advance only in DRAW cycles, giving a replayable sequence.

Structure
REQ-018 Package rand_server_pkg SHALL hold the state enum (IDLE, DRAW, DONE), LFSR_W = 16, OUT_W = 8 and the tap positions.
REQ-019 The LFSR SHALL be sub-module rand_lfsr16 with inputs clk, reset, step and seed parameter, and a 16-bit output. Arbiter and FSM SHALL stay in rand_server.

Verification (macro undefined unless stated)
REQ-020 lim0=200, req=0001 after reset: ack=0001 at t+2 with rnd_data=8'hAA (170 < 200).
REQ-021 lim1=1, req=0010: ack=0010 at t+2, rnd_data=0. Also lim1=0: same result.
REQ-022 All lim=16, req=1111 held continuously: acks in order 0001, 0010, 0100, 1000, 0001; each rnd_data < 16.
REQ-023 lim0=3 (mask=3), forced LFSR producing candidate 3 for MAX_TRY draws: fallback ack at t+1+MAX_TRY with rnd_data=1.
REQ-024 reset asserted in the first DRAW cycle: no ack; then req0 with lim0=200 gives rnd_data=8'hAA again.
REQ-025 With RAND_SERVER_FREERUN_EN defined, 5 idle cycles then req0 with lim0=256-equivalent 0xFF: rnd_data equals the LFSR state after 5 steps, low byte, if below 255.
